// File: rtl/mpsoc_uart_pkg.sv
// Shared definitions for the UART receive path.
//  - rx_state_t   : receiver FSM state encoding (also exported on the debug port)
//  - LCR_*        : bit positions inside the 6-bit line-control word
//  - OVERSAMPLE_DEFAULT : ticks per bit used when the top is not overridden
//  - align_data   : right-justifies a character assembled MSB-first in a shift reg
package mpsoc_uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  // Line-control word layout: [1:0] word length - 5, [2] two stop bits,
  // [3] parity enable, [4] even parity, [5] stick parity.
  localparam int LCR_WLS = 0;
  localparam int LCR_STB = 2;
  localparam int LCR_PEN = 3;
  localparam int LCR_EPS = 4;
  localparam int LCR_SP  = 5;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Bits enter the shift register at the top, so a 5..8 bit character ends
  // up in the upper bits; shift it down by (8 - length) = (3 - wls).
  function automatic logic [7:0] align_data(input logic [7:0] sh, input logic [1:0] wls);
    return sh >> (2'd3 - wls);
  endfunction

endpackage

// File: rtl/mpsoc_uart_baud_gen.sv
// Oversample tick generator.
//  clk_i, rstn_i : clock, asynchronous active-low reset
//  baud_div_i    : clocks per tick (0 behaves as 1)
//  restart_i     : forces the counter back to 0 so the tick grid aligns to an event
//  tick_o        : one-clock pulse when the counter wraps
module mpsoc_uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic                 restart_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic [DIV_WIDTH-1:0] div_last;

  always_comb begin
    div_last = (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
    tick_o   = 1'b0;
    cnt_d    = cnt_q + 1'b1;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q >= div_last) begin
      // ">=" so a divisor lowered below the current count wraps at once
      cnt_d  = '0;
      tick_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mpsoc_uart_rx.sv
// UART serial receiver with oversampled bit recovery.
//  clk_i, rstn_i  : clock, asynchronous active-low reset
//  rx_i           : asynchronous serial line, idle high
//  baud_div_i     : clocks per oversample tick
//  lcr_i          : line control, latched at each start edge
//  rx_data_o      : received character, right-justified
//  rx_valid_o     : one-clock strobe qualifying data and error flags
//  parity_err_o, framing_err_o, break_o : per-character status, held until next strobe
//  busy_o         : confirmed start bit until strobe
//  dbg_state_o    : current FSM state
//
// Handshake: rx_valid_o is a push-only strobe with no ready; the consumer must
// take rx_data_o and the flags in the same cycle rx_valid_o is high.
module mpsoc_uart_rx
  import mpsoc_uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic [5:0]           lcr_i,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  output logic                 parity_err_o,
  output logic                 framing_err_o,
  output logic                 break_o,
  output logic                 busy_o,
  output rx_state_t            dbg_state_o
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  rx_state_t       state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [5:0]      lcr_q, lcr_d;
  logic            armed_q, armed_d;
  logic            busy_q, busy_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            brk_q, brk_d;

  logic       rx_s;
  logic       tick;
  logic       start_det;
  logic       mid, last;
  logic [2:0] word_last;
  logic [7:0] data_al;
  logic       exp_par;
  logic       unused_stb;

  // The second stop bit is never checked, so the STB field has no effect here.
  assign unused_stb = lcr_i[LCR_STB] ^ lcr_q[LCR_STB];

  assign rx_s      = sync2_q;
  assign start_det = (state_q == RX_IDLE) && armed_q && !rx_s;
  assign mid       = tick && (os_cnt_q == OS_MID);
  assign last      = tick && (os_cnt_q == OS_LAST);
  assign word_last = 3'd4 + {1'b0, lcr_q[LCR_WLS +: 2]};
  assign data_al   = align_data(shift_q, lcr_q[LCR_WLS +: 2]);
  assign exp_par   = lcr_q[LCR_SP] ? ~lcr_q[LCR_EPS]
                   : (lcr_q[LCR_EPS] ? ^data_al : ~^data_al);

  mpsoc_uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud_gen (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .baud_div_i (baud_div_i),
    .restart_i  (start_det),
    .tick_o     (tick)
  );

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:   if (start_det) state_d = RX_START;
      RX_START: begin
        if (mid && rx_s) state_d = RX_IDLE;   // glitch, not a real start bit
        else if (last)   state_d = RX_DATA;
      end
      RX_DATA:   if (last && (bit_cnt_q == word_last))
                   state_d = lcr_q[LCR_PEN] ? RX_PARITY : RX_STOP;
      RX_PARITY: if (last) state_d = RX_STOP;
      // Leave at mid stop bit so the next start edge can be caught right away.
      RX_STOP:   if (mid) state_d = RX_IDLE;
      default:   state_d = RX_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    lcr_d     = lcr_q;
    busy_d    = busy_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    brk_d     = brk_q;
    // Only arm after a high line on a tick, so a line stuck low (break)
    // cannot retrigger a character.
    armed_d   = (state_q == RX_IDLE) && !start_det && (armed_q || (tick && rx_s));

    if (start_det) begin
      os_cnt_d = '0;
      shift_d  = '0;
      lcr_d    = lcr_i;
    end else if (tick && (state_q != RX_IDLE)) begin
      os_cnt_d = os_cnt_q + 1'b1;   // wraps naturally at OVERSAMPLE
    end

    case (state_q)
      RX_START: begin
        bit_cnt_d = '0;
        if (mid && !rx_s) busy_d = 1'b1;
      end
      RX_DATA: begin
        if (mid)  shift_d   = {rx_s, shift_q[7:1]};
        if (last) bit_cnt_d = bit_cnt_q + 1'b1;
      end
      RX_PARITY: if (mid) par_d = rx_s;
      RX_STOP: begin
        if (mid) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          data_d  = data_al;
          perr_d  = lcr_q[LCR_PEN] && (par_q != exp_par);
          ferr_d  = !rx_s;
          brk_d   = (data_al == 8'h00) && (!lcr_q[LCR_PEN] || !par_q) && !rx_s;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      lcr_q     <= '0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      lcr_q     <= lcr_d;
      armed_q   <= armed_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
    end
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign parity_err_o  = perr_q;
  assign framing_err_o = ferr_q;
  assign break_o       = brk_q;
  assign busy_o        = busy_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mpsoc_uart_rx.sv
// Directed plus randomized bench for mpsoc_uart_rx. A frame-level model turns
// (character, line control, parity bit sent, stop bit sent) into the expected
// {break, framing, parity, data} result; a monitor collects every strobe.
module tb_mpsoc_uart_rx;

  logic        clk;
  logic        rstn;
  logic        rx;
  logic [15:0] div;
  logic [5:0]  lcr;
  logic [7:0]  rx_data;
  logic        rx_valid, perr, ferr, brk, busy;
  mpsoc_uart_pkg::rx_state_t dbg_state;

  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  int n_vec = 0;
  int n_err = 0;

  mpsoc_uart_rx dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .rx_i          (rx),
    .baud_div_i    (div),
    .lcr_i         (lcr),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .parity_err_o  (perr),
    .framing_err_o (ferr),
    .break_o       (brk),
    .busy_o        (busy),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rx_valid) obs_q.push_back({brk, ferr, perr, rx_data});
  end

  // ---------------- reference model ----------------
  function automatic logic good_parity(input logic [7:0] d, input logic [5:0] l);
    int n;
    int ones;
    n = 5 + int'(l[1:0]);
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    if (l[5]) return !l[4];
    if (l[4]) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  function automatic logic [10:0] model(input logic [7:0] d, input logic [5:0] l,
                                        input logic pbit, input logic stopv);
    int         n;
    logic [7:0] dm;
    logic       pe, fe, bk;
    n  = 5 + int'(l[1:0]);
    dm = 8'h00;
    for (int i = 0; i < n; i++) dm[i] = d[i];
    pe = l[3] && (pbit != good_parity(d, l));
    fe = !stopv;
    bk = (dm == 8'h00) && (!l[3] || !pbit) && !stopv;
    return {bk, fe, pe, dm};
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clks(16 * int'(div));
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    wait_clks(16 * int'(div) * n);
  endtask

  // lcr_i is scrambled after the start bit: the DUT must use the latched copy.
  task automatic send_char(input logic [7:0] d, input logic [5:0] l,
                           input logic pbit, input logic stopv);
    int n;
    n   = 5 + int'(l[1:0]);
    lcr = l;
    exp_q.push_back(model(d, l, pbit, stopv));
    drive_bit(1'b0);
    lcr = 6'($urandom);
    for (int i = 0; i < n; i++) drive_bit(d[i]);
    if (l[3]) drive_bit(pbit);
    drive_bit(stopv);
    if (l[2]) drive_bit(1'b1);
    rx = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_frames(input string tag, input int exp_cnt);
    logic [10:0] got, exp;
    n_vec++;
    assert (obs_q.size() == exp_cnt) else begin
      n_err++;
      $error("FAIL %s_count: observed %0d expected %0d", tag, obs_q.size(), exp_cnt);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      got = obs_q.pop_front();
      exp = exp_q.pop_front();
      n_vec++;
      assert (got === exp) else begin
        n_err++;
        $error("FAIL %s_frame: observed brk/fe/pe/data=%h expected %h", tag, got, exp);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    logic [12:0] got;
    got = {rx_valid, rx_data, perr, ferr, brk, busy};
    n_vec++;
    assert (got === 13'h0) else begin
      n_err++;
      $error("FAIL %s: observed %h expected 0000", tag, got);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic [5:0] l;
    logic       pb, sv;

    rx   = 1'b1;
    rstn = 1'b0;
    div  = 16'd1;
    lcr  = 6'b000011;
    wait_clks(5);
    check_idle_outputs("reset_active");
    rstn = 1'b1;
    wait_clks(3);
    check_idle_outputs("reset_released");
    idle_bits(2);

    // 8N1 0xA5
    send_char(8'hA5, 6'b000011, 1'b0, 1'b1);
    idle_bits(2);
    check_frames("8n1_a5", 1);

    // 7E1 0x35, parity bit forced to 1 (even parity wants 0)
    send_char(8'h35, 6'b011010, 1'b1, 1'b1);
    idle_bits(2);
    check_frames("7e1_parity_err", 1);

    // 8N1 0x3C with stop bit low
    send_char(8'h3C, 6'b000011, 1'b0, 1'b0);
    idle_bits(2);
    check_frames("framing_err", 1);

    // Break: 40 bit times low, one strobe only
    lcr = 6'b000011;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 8'h00});
    rx = 1'b0;
    wait_clks(16 * 40);
    idle_bits(2);
    check_frames("break", 1);
    send_char(8'h55, 6'b000011, 1'b0, 1'b1);
    idle_bits(2);
    check_frames("after_break_55", 1);

    // 3-tick glitch: false start, busy never raised
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(9);
    n_vec++;
    assert (busy === 1'b0) else begin
      n_err++;
      $error("FAIL glitch_busy: observed %b expected 0", busy);
    end
    idle_bits(2);
    check_frames("glitch", 0);
    send_char(8'hC3, 6'b000011, 1'b0, 1'b1);
    idle_bits(2);
    check_frames("after_glitch_c3", 1);

    // Randomized frames: length, parity mode, stop count, divisor, errors
    for (int k = 0; k < 20; k++) begin
      div = 16'($urandom_range(1, 3));
      idle_bits(2);
      d  = 8'($urandom);
      l  = 6'($urandom);
      pb = good_parity(d, l) ^ ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) != 0);
      send_char(d, l, pb, sv);
      idle_bits(1 + $urandom_range(0, 2));
      check_frames("random", 1);
    end

    // Back-to-back at divisor 3, reset mid second character
    div = 16'd3;
    idle_bits(2);
    send_char(8'h01, 6'b000011, 1'b0, 1'b1);
    d = 8'hFE;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    n_vec++;
    assert (busy === 1'b1) else begin
      n_err++;
      $error("FAIL b2b_busy: observed %b expected 1", busy);
    end
    rstn = 1'b0;
    rx   = 1'b1;
    wait_clks(2);
    check_idle_outputs("reset_mid_char");
    wait_clks(16 * 3 * 12);
    check_frames("b2b_reset", 1);
    rstn = 1'b1;
    idle_bits(2);
    send_char(8'h5A, 6'b000011, 1'b0, 1'b1);
    idle_bits(2);
    check_frames("after_reset_5a", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
